// File: rtl/os_cache_pkg.sv
// os_cache_pkg: shared FSM states, cache opcodes, default geometry and config check
package os_cache_pkg;
  localparam int WA_ROWS = 256;
  localparam int P_ROWS = 32;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD_W, LOAD_A, COMPUTE, LOAD_P, SEND_P, DONE} state_e;
  localparam logic [2:0] LD_W = 3'b000;
  localparam logic [2:0] LD_A = 3'b001;
  localparam logic [2:0] TX_W = 3'b010;
  localparam logic [2:0] TX_A = 3'b011;
  localparam logic [2:0] TX_WA = 3'b100;
  localparam logic [2:0] LD_P = 3'b101;
  localparam logic [2:0] TX_P = 3'b110;
  localparam logic [2:0] NOP = 3'b111;
  function automatic logic cfg_ok(input logic [8:0] k, input logic [5:0] n, input int wa, input int p);
    return k != '0 && int'(k) <= wa && n != '0 && int'(n) <= p && int'(k) * int'(n) <= wa;
  endfunction
endpackage

// File: rtl/nested_counter.sv
// nested_counter: two-level o/k counter that wraps to zero after the last pair; n_lim_i=1 gives a flat count
module nested_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] k_lim_i,
  input  logic [W-1:0] n_lim_i,
  output logic [W-1:0] k_o,
  output logic         last_inner_o,
  output logic         last_all_o
);
  logic [W-1:0] o_q, k_q;
  assign k_o = k_q;
  assign last_inner_o = k_q == k_lim_i - W'(1);
  assign last_all_o = last_inner_o && o_q == n_lim_i - W'(1);
  always_ff @(posedge clk) begin
    if (rst || clr_i || (en_i && last_all_o)) begin
      o_q <= '0;
      k_q <= '0;
    end else if (en_i) begin
      k_q <= last_inner_o ? '0 : k_q + W'(1);
      o_q <= o_q + W'(last_inner_o);
    end
  end
endmodule

// File: rtl/os_cache_sequencer.sv
// os_cache_sequencer: walks the output-stationary cache through load, compute and psum drain of one tile
module os_cache_sequencer
  import os_cache_pkg::*;
#(
  parameter int wa_rows = WA_ROWS,
  parameter int p_rows = P_ROWS
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_start,
  input  logic       w_clear,
  input  logic [8:0] w_k,
  input  logic [5:0] w_n_out,
  input  logic       w_bus_valid,
  input  logic       w_glb_valid,
  input  logic       w_pe_stall,
  input  logic       w_out_stall,
  output logic       r_cache_ready,
  output logic [2:0] r_cache_state,
  output logic [7:0] r_w_addr,
  output logic [7:0] r_a_addr,
  output logic       r_bus_ready,
  output logic       r_glb_ready,
  output logic       r_pair_valid,
  output logic       r_last_k,
  output logic       r_psum_valid,
  output logic       r_busy,
  output logic       r_done,
  output logic       r_err
);
  state_e state_q, state_d;
  logic [8:0] k_q, n_q, nk_q, in_lim, out_lim, cnt_k;
  logic [7:0] flat_q;
  logic [2:0] op;
  logic last_in, last_all, issue, ok;
  logic ready_q, pair_q, last_k_q, psum_q, done_q, err_q;
  assign ok = cfg_ok(w_k, w_n_out, wa_rows, p_rows);
  always_comb begin
    issue = (state_q == LOAD_W || state_q == LOAD_A) ? w_bus_valid :
            state_q == COMPUTE ? !w_pe_stall :
            state_q == LOAD_P ? w_glb_valid :
            state_q == SEND_P ? !w_out_stall : 1'b0;
    op = state_q == LOAD_W ? LD_W : state_q == LOAD_A ? LD_A :
         state_q == COMPUTE ? TX_WA : state_q == LOAD_P ? LD_P : TX_P;
    in_lim = state_q == LOAD_W ? nk_q : (state_q == LOAD_A || state_q == COMPUTE) ? k_q : n_q;
    out_lim = state_q == COMPUTE ? n_q : 9'd1;
    state_d = state_q;
    case (state_q)
      IDLE: if (w_start && ok) state_d = w_clear ? CLEAR : LOAD_W;
      CLEAR: state_d = LOAD_W;
      LOAD_W: if (issue && last_all) state_d = LOAD_A;
      LOAD_A: if (issue && last_all) state_d = COMPUTE;
      COMPUTE: if (issue && last_all) state_d = LOAD_P;
      LOAD_P: if (issue && last_all) state_d = SEND_P;
      SEND_P: if (issue && last_all) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  nested_counter #(.W(9)) u_cnt (
    .clk(w_clk),
    .rst(w_rst),
    .en_i(issue),
    .clr_i(state_q == IDLE),
    .k_lim_i(in_lim),
    .n_lim_i(out_lim),
    .k_o(cnt_k),
    .last_inner_o(last_in),
    .last_all_o(last_all)
  );
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      flat_q <= '0;
      pair_q <= 1'b0;
      last_k_q <= 1'b0;
      psum_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= state_d != CLEAR;
      flat_q <= state_q != COMPUTE ? '0 : flat_q + 8'(issue);
      pair_q <= issue && state_q == COMPUTE;
      last_k_q <= issue && state_q == COMPUTE && last_in;
      psum_q <= issue && state_q == SEND_P;
      done_q <= state_q == DONE;
      err_q <= state_q == IDLE && w_start && !ok;
    end
  end
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      k_q <= '0;
      n_q <= '0;
      nk_q <= '0;
    end else if (state_q == IDLE && w_start) begin
      k_q <= w_k;
      n_q <= {3'b0, w_n_out};
      nk_q <= 9'(w_k * {3'b0, w_n_out});
    end
  end
  // o*K+k in COMPUTE is just the running pair index, so no multiplier is needed
  assign r_w_addr = state_q == COMPUTE ? flat_q :
                    (state_q == LOAD_W || state_q == LOAD_P || state_q == SEND_P) ? 8'(cnt_k) : '0;
  assign r_a_addr = (state_q == LOAD_A || state_q == COMPUTE) ? 8'(cnt_k) : '0;
  assign r_cache_ready = ready_q;
  assign r_cache_state = issue ? op : NOP;
  assign r_bus_ready = issue && (state_q == LOAD_W || state_q == LOAD_A);
  assign r_glb_ready = issue && state_q == LOAD_P;
  assign r_pair_valid = pair_q;
  assign r_last_k = last_k_q;
  assign r_psum_valid = psum_q;
  assign r_busy = state_q != IDLE;
  assign r_done = done_q;
  assign r_err = err_q;
endmodule

// File: tb/tb_os_cache_sequencer.sv
// tb_os_cache_sequencer: config table, directed corner tiles and random tiles against an op-list model
module tb_os_cache_sequencer;
  import os_cache_pkg::*;
  typedef struct { logic [2:0] op; int w; int a; bit last; } op_t;
  typedef struct { int k; int n; bit clr; bit err; } cfg_t;
  logic w_clk = 0, w_rst = 1, w_start = 0, w_clear = 0;
  logic w_bus_valid = 0, w_glb_valid = 0, w_pe_stall = 0, w_out_stall = 0;
  logic [8:0] w_k = 0;
  logic [5:0] w_n_out = 0;
  logic r_cache_ready, r_bus_ready, r_glb_ready, r_pair_valid, r_last_k, r_psum_valid, r_busy, r_done, r_err;
  logic [2:0] r_cache_state;
  logic [7:0] r_w_addr, r_a_addr;
  int vecs = 0, errs = 0;
  op_t q[$];
  always #5 w_clk = ~w_clk;
  os_cache_sequencer dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_start(w_start), .w_clear(w_clear), .w_k(w_k), .w_n_out(w_n_out),
    .w_bus_valid(w_bus_valid), .w_glb_valid(w_glb_valid), .w_pe_stall(w_pe_stall), .w_out_stall(w_out_stall),
    .r_cache_ready(r_cache_ready), .r_cache_state(r_cache_state), .r_w_addr(r_w_addr), .r_a_addr(r_a_addr),
    .r_bus_ready(r_bus_ready), .r_glb_ready(r_glb_ready), .r_pair_valid(r_pair_valid), .r_last_k(r_last_k),
    .r_psum_valid(r_psum_valid), .r_busy(r_busy), .r_done(r_done), .r_err(r_err)
  );
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, r_cache_ready, 0);
    chk({tag, "_opcode"}, r_cache_state, NOP);
    chk({tag, "_w_addr"}, r_w_addr, 0);
    chk({tag, "_a_addr"}, r_a_addr, 0);
    chk({tag, "_flags"}, {r_bus_ready, r_glb_ready, r_pair_valid, r_last_k, r_psum_valid, r_busy, r_done, r_err}, 0);
  endtask
  task automatic reject(input int k, input int n);
    w_k = 9'(k); w_n_out = 6'(n); w_clear = 0; w_start = 1;
    @(posedge w_clk); #1; w_start = 0;
    @(negedge w_clk);
    chk("err_pulse", r_err, 1);
    chk("err_busy", r_busy, 0);
    chk("err_opcode", r_cache_state, NOP);
    @(posedge w_clk); #1;
    @(negedge w_clk);
    chk("err_one_cycle", r_err, 0);
    chk("err_stay_idle", r_busy, 0);
  endtask
  // pat: 0 random, 1 clean, 2 bus_valid toggling, 3 three-cycle PE stall plus ignored start
  task automatic run_tile(input int k, input int n, input bit clr, input int pat, input bit abort, output int done_cyc);
    op_t e;
    int clr_left, since, cyc, npairs, nstall;
    bit gate, hd, pp, pl, ps, ab;
    logic [2:0] hop;
    q.delete();
    for (int i = 0; i < n * k; i++) q.push_back(op_t'{LD_W, i, 0, 1'b0});
    for (int i = 0; i < k; i++) q.push_back(op_t'{LD_A, 0, i, 1'b0});
    for (int o = 0; o < n; o++) for (int j = 0; j < k; j++) q.push_back(op_t'{TX_WA, o * k + j, j, j == k - 1});
    for (int o = 0; o < n; o++) q.push_back(op_t'{LD_P, o, 0, 1'b0});
    for (int o = 0; o < n; o++) q.push_back(op_t'{TX_P, o, 0, 1'b0});
    clr_left = clr; since = -1; cyc = 0; npairs = 0; nstall = 0; pp = 0; pl = 0; ps = 0; done_cyc = -1;
    w_k = 9'(k); w_n_out = 6'(n); w_clear = clr; w_start = 1;
    @(posedge w_clk); #1;
    forever begin
      cyc++;
      hd = q.size() > 0;
      hop = hd ? q[0].op : NOP;
      w_start = 0; w_clear = 0;
      w_bus_valid = pat == 0 ? 1'($urandom_range(0, 1)) : pat == 2 ? 1'(cyc % 2) : 1'b1;
      w_glb_valid = pat == 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      w_out_stall = pat == 0 ? $urandom_range(0, 3) == 0 : 1'b0;
      w_pe_stall = pat == 0 ? $urandom_range(0, 3) == 0 : pat == 3 && hop == TX_WA && npairs == 3 && nstall < 3;
      if (pat == 3 && w_pe_stall) nstall++;
      if (hd && ((pat == 0 && $urandom_range(0, 7) == 0) || (pat == 3 && npairs == 5))) begin
        w_start = 1; w_clear = 1'($urandom_range(0, 1));
        w_k = 9'($urandom_range(1, 20)); w_n_out = 6'($urandom_range(1, 8));
      end
      ab = abort && hop == LD_P;
      w_rst = ab;
      @(negedge w_clk);
      chk("busy", r_busy, since < 2);
      chk("done", r_done, since == 2);
      chk("err_quiet", r_err, 0);
      chk("pair_valid", r_pair_valid, pp);
      chk("last_k", r_last_k, pl);
      chk("psum_valid", r_psum_valid, ps);
      gate = 0; pp = 0; pl = 0; ps = 0;
      if (clr_left > 0) begin
        chk("clear_ready", r_cache_ready, 0);
        clr_left--;
      end else begin
        chk("cache_ready", r_cache_ready, 1);
        gate = hop == TX_WA ? !w_pe_stall : hop == LD_P ? w_glb_valid : hop == TX_P ? !w_out_stall : hd && w_bus_valid;
      end
      chk("opcode", r_cache_state, gate ? hop : NOP);
      chk("bus_ready", r_bus_ready, gate && (hop == LD_W || hop == LD_A));
      chk("glb_ready", r_glb_ready, gate && hop == LD_P);
      if (gate) begin
        e = q.pop_front();
        if (e.op != LD_A) chk("w_addr", r_w_addr, e.w);
        if (e.op == LD_A || e.op == TX_WA) chk("a_addr", r_a_addr, e.a);
        pp = e.op == TX_WA;
        pl = pp && e.last;
        ps = e.op == TX_P;
        if (pp) npairs++;
        if (q.size() == 0) since = 0;
      end
      if (since == 2) done_cyc = cyc;
      if (since >= 0) since++;
      if (ab) begin
        @(posedge w_clk); #1; w_rst = 0;
        @(negedge w_clk);
        chk_reset("abort");
        repeat (6) begin
          @(posedge w_clk); #1;
          @(negedge w_clk);
          chk("abort_ready", r_cache_ready, 1);
          chk("abort_no_done", r_done, 0);
          chk("abort_idle", r_busy, 0);
        end
        return;
      end
      if (since > 3) return;
      if (cyc > 5000) begin
        vecs++; errs++;
        $display("FAIL tile_timeout: got %0d ops left expected 0", q.size());
        return;
      end
      @(posedge w_clk); #1;
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    cfg_t tbl[$];
    int dc, k, n;
    tbl.push_back(cfg_t'{16, 17, 1'b0, 1'b1});
    tbl.push_back(cfg_t'{0, 4, 1'b0, 1'b1});
    tbl.push_back(cfg_t'{300, 1, 1'b0, 1'b1});
    tbl.push_back(cfg_t'{4, 0, 1'b0, 1'b1});
    tbl.push_back(cfg_t'{1, 33, 1'b0, 1'b1});
    tbl.push_back(cfg_t'{9, 32, 1'b0, 1'b1});
    tbl.push_back(cfg_t'{4, 2, 1'b0, 1'b0});
    tbl.push_back(cfg_t'{4, 2, 1'b1, 1'b0});
    tbl.push_back(cfg_t'{256, 1, 1'b0, 1'b0});
    tbl.push_back(cfg_t'{1, 32, 1'b0, 1'b0});
    tbl.push_back(cfg_t'{8, 32, 1'b1, 1'b0});
    tbl.push_back(cfg_t'{3, 5, 1'b0, 1'b0});
    repeat (2) @(posedge w_clk);
    @(negedge w_clk);
    chk_reset("reset");
    @(posedge w_clk); #1; w_rst = 0;
    @(posedge w_clk); #1;
    @(negedge w_clk);
    chk("ready_after_reset", r_cache_ready, 1);
    chk("idle_not_busy", r_busy, 0);
    foreach (tbl[i]) begin
      if (tbl[i].err) reject(tbl[i].k, tbl[i].n);
      else begin
        run_tile(tbl[i].k, tbl[i].n, tbl[i].clr, 1, 1'b0, dc);
        chk("done_latency", dc, 2 * tbl[i].n * tbl[i].k + tbl[i].k + 2 * tbl[i].n + 2 + int'(tbl[i].clr));
      end
    end
    run_tile(4, 2, 1'b0, 2, 1'b0, dc);
    run_tile(4, 2, 1'b0, 3, 1'b0, dc);
    run_tile(2, 1, 1'b1, 1, 1'b1, dc);
    repeat (20) begin
      n = $urandom_range(1, 8);
      k = $urandom_range(1, 256 / n > 24 ? 24 : 256 / n);
      run_tile(k, n, 1'($urandom_range(0, 1)), 0, 1'b0, dc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
